// File: rtl/excess3_pkg.sv
// Shared Excess-3 constants and FSM state encoding for the BCD<->Excess-3 encoder/decoder pair.
// Both directions use the same offsets, so a change here keeps the pair consistent.
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET   = 4'd3;
  localparam logic [3:0] E3_MIN      = 4'd3;
  localparam logic [3:0] E3_MAX      = 4'd12;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic e3_is_legal(input logic [3:0] e_d);
    return (e_d >= E3_MIN) && (e_d <= E3_MAX);
  endfunction

  function automatic logic [3:0] e3_decode(input logic [3:0] e_d);
    return e3_is_legal(e_d) ? (e_d - E3_OFFSET) : BCD_INVALID;
  endfunction

endpackage

// File: rtl/excess3_to_bcd_ser_if.sv
// Handshake bundle for the serial Excess-3 -> BCD decoder: input word channel and result channel.
// master = producer/consumer side, slave = decoder side.
interface excess3_to_bcd_ser_if #(
  parameter int DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   e;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   b;
  logic [DIGITS-1:0]     err_mask;
  logic                  err;

  modport master (
    output in_valid, e, out_ready,
    input  in_ready, out_valid, b, err_mask, err
  );

  modport slave (
    input  in_valid, e, out_ready,
    output in_ready, out_valid, b, err_mask, err
  );

endinterface

// File: rtl/excess3_digit_dec.sv
// Single-digit Excess-3 -> BCD decode, purely combinational (zero latency, no backpressure).
// Codes outside 3..12 map to 4'hF and raise invalid.
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [3:0] e_d,
  output logic [3:0] b_d,
  output logic       invalid
);

  assign invalid = ~e3_is_legal(e_d);
  assign b_d     = e3_decode(e_d);

endmodule

// File: rtl/excess3_to_bcd_ser.sv
// Serial Excess-3 -> BCD word decoder, one digit per clock LSD first; result valid DIGITS cycles after accept.
// Backpressure: the result is held in DONE until out_ready; no new word is accepted until the cycle after.
module excess3_to_bcd_ser
  import excess3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  excess3_to_bcd_ser_if.slave  io
);

  localparam int              CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [4*DIGITS-1:0]   cap;
  logic [4*DIGITS-1:0]   b_r;
  logic [DIGITS-1:0]     mask_r;
  logic                  out_valid_r;

  logic [3:0]            cur_e;
  logic [3:0]            cur_b;
  logic                  cur_inv;

  // One shared decoder; the counter walks it across the captured word.
  assign cur_e = cap[4*cnt +: 4];

  excess3_digit_dec u_dec (
    .e_d     (cur_e),
    .b_d     (cur_b),
    .invalid (cur_inv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap         <= '0;
      b_r         <= '0;
      mask_r      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            cap    <= io.e;
            b_r    <= '0;
            mask_r <= '0;
            cnt    <= '0;
            state  <= CONV;
          end
        end
        CONV: begin
          b_r[4*cnt +: 4] <= cur_b;
          mask_r[cnt]     <= cur_inv;
          if (cnt == LAST_CNT) begin
            cnt         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE) & ~rst;
  assign io.out_valid = out_valid_r;
  assign io.b         = b_r;
  assign io.err_mask  = mask_r;
  assign io.err       = |mask_r;

endmodule
